tdc_result_queue: RTL and testbench

//   Buffers 40-bit TDC measurement words from the capture logic and feeds them
//   one at a time to the UART hex transmitter (data/data_valid/busy interface).

---
 rtl/tdc_result_queue_if.sv | 10 +
 rtl/tdc_result_queue.sv | 66 ++++++
 tb/tb_tdc_result_queue.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/tdc_result_queue_if.sv
// tdc_result_queue_if: capture-side strobe and transmitter handshake for the TDC result queue
interface tdc_result_queue_if #(parameter int WIDTH = 40);
  logic [WIDTH-1:0] in_data;
  logic in_valid;
  logic [WIDTH-1:0] out_data;
  logic out_valid;
  logic tx_busy;
  modport master (output in_data, in_valid, tx_busy, input out_data, out_valid);
  modport slave (input in_data, in_valid, tx_busy, output out_data, out_valid);
endinterface

// File: rtl/tdc_result_queue.sv
// tdc_result_queue: FIFO draining TDC words to a busy-gated UART transmitter; TDC_QUEUE_DROP_COUNT_EN adds drop_count
module tdc_result_queue #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input logic clk,
  input logic rst,
  tdc_result_queue_if.slave q,
  output logic [ADDR_W:0] level,
  output logic empty,
  output logic full,
  output logic overflow
`ifdef TDC_QUEUE_DROP_COUNT_EN
  ,output logic [15:0] drop_count
`endif
);
  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic wr, pop;
  assign empty = level == '0;
  assign full = level == (ADDR_W+1)'(DEPTH);
  assign wr = q.in_valid && !full;
  assign pop = state == IDLE && !empty && !q.tx_busy;
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= q.in_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      q.out_valid <= 1'b0;
      q.out_data <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      level <= level + {{ADDR_W{1'b0}}, wr} - {{ADDR_W{1'b0}}, pop};
      overflow <= overflow | (q.in_valid && full);
      case (state)
        IDLE: begin
          q.out_valid <= pop;
          if (pop) begin
            q.out_data <= mem[rd_ptr];
            state <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          q.out_valid <= 1'b0;
          state <= q.tx_busy ? WAIT_DONE : WAIT_BUSY;
        end
        WAIT_DONE: state <= q.tx_busy ? WAIT_DONE : IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef TDC_QUEUE_DROP_COUNT_EN
  // Saturating count of words refused because the queue was already full
  always_ff @(posedge clk)
    if (rst) drop_count <= '0;
    else if (q.in_valid && full && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
`endif
endmodule

// File: tb/tb_tdc_result_queue.sv
// tb_tdc_result_queue: directed and random stimulus against a word-queue model with a busy-flag transmitter model
module tb_tdc_result_queue;
  localparam int WIDTH = 40;
  localparam int DEPTH = 8;
  logic clk = 0;
  logic rst;
  logic [3:0] level;
  logic empty, full, overflow;
`ifdef TDC_QUEUE_DROP_COUNT_EN
  logic [15:0] drop_count;
`endif
  tdc_result_queue_if #(.WIDTH(WIDTH)) bus();
  tdc_result_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .q(bus.slave), .level(level), .empty(empty), .full(full), .overflow(overflow)
`ifdef TDC_QUEUE_DROP_COUNT_EN
    , .drop_count(drop_count)
`endif
  );
  always #5 clk = ~clk;
  int passed = 0, total = 0;
  logic [WIDTH-1:0] mq[$];
  int drops = 0;
  int pulses = 0;
  int busy_cnt = 0, busy_len = 0;
  bit dly = 0, ov_prev = 0, started = 0, tx_force = 0, busy_at_edge;
  assign bus.tx_busy = tx_force | (busy_cnt != 0);
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask
  task automatic wr(input logic [WIDTH-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_data = d;
    cyc(1);
    bus.in_valid = 1'b0;
  endtask
  task automatic drain(input string tag);
    int n = 0;
    tx_force = 0;
    while ((mq.size() != 0 || busy_cnt != 0 || dly) && n < 3000) begin
      cyc(1);
      n++;
    end
    cyc(2);
    chk(tag, 64'(n < 3000), 64'd1);
  endtask
  // Reference queue: arrival decision uses occupancy before this edge's pop
  always @(posedge clk) begin
    busy_at_edge = bus.tx_busy;
    if (rst) begin
      mq.delete();
      drops = 0;
    end else if (bus.in_valid === 1'b1) begin
      if (mq.size() == DEPTH) drops++;
      else mq.push_back(bus.in_data);
    end
  end
  // Transmitter model: busy rises one cycle after it samples the start pulse
  always @(negedge clk) begin
    if (started) begin
      if (bus.out_valid) begin
        pulses++;
        chk("pulse_back_to_back", 64'(ov_prev), 64'd0);
        chk("pulse_while_busy", 64'(busy_at_edge), 64'd0);
        chk("pulse_spurious", 64'(mq.size() != 0), 64'd1);
        if (mq.size() != 0) chk("pulse_data", 64'(bus.out_data), 64'(mq.pop_front()));
      end
      chk("level", 64'(level), 64'(mq.size()));
      chk("empty", 64'(empty), 64'(mq.size() == 0));
      chk("full", 64'(full), 64'(mq.size() == DEPTH));
      chk("overflow", 64'(overflow), 64'(drops != 0));
`ifdef TDC_QUEUE_DROP_COUNT_EN
      chk("drop_count", 64'(drop_count), 64'(drops > 65535 ? 65535 : drops));
`endif
    end
    ov_prev = bus.out_valid;
    if (dly) begin
      dly = 0;
      busy_cnt = busy_len != 0 ? busy_len : int'($urandom_range(2, 12));
    end else if (busy_cnt != 0) busy_cnt--;
    if (bus.out_valid) dly = 1;
  end
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    int p0;
    rst = 1;
    bus.in_valid = 0;
    bus.in_data = '0;
    cyc(3);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
`ifdef TDC_QUEUE_DROP_COUNT_EN
    chk("rst_drop_count", 64'(drop_count), 64'd0);
`endif
    rst = 0;
    started = 1;
    cyc(1);
    busy_len = 20;
    wr(40'h12_3456_789A);
    chk("t1_no_early_pulse", 64'(bus.out_valid), 64'd0);
    cyc(1);
    chk("t1_pulse", 64'(bus.out_valid), 64'd1);
    chk("t1_data", 64'(bus.out_data), 64'h12_3456_789A);
    cyc(25);
    chk("t1_single_pulse", 64'(pulses), 64'd1);
    chk("t1_level", 64'(level), 64'd0);
    drain("t1_drain");
    busy_len = 0;
    tx_force = 1;
    p0 = pulses;
    for (int i = 1; i <= 8; i++) wr(40'(i));
    chk("t2_full", 64'(full), 64'd1);
    chk("t2_level", 64'(level), 64'd8);
    chk("t2_no_pulse", 64'(pulses), 64'(p0));
    drain("t2_drain");
    chk("t2_pulses", 64'(pulses - p0), 64'd8);
    rst = 1;
    cyc(1);
    rst = 0;
    tx_force = 1;
    p0 = pulses;
    for (int i = 0; i < 10; i++) wr({8'(i), $urandom});
    chk("t3_level", 64'(level), 64'd8);
    chk("t3_overflow", 64'(overflow), 64'd1);
`ifdef TDC_QUEUE_DROP_COUNT_EN
    chk("t3_drop_count", 64'(drop_count), 64'd2);
`endif
    drain("t3_drain");
    chk("t3_pulses", 64'(pulses - p0), 64'd8);
    tx_force = 1;
    for (int i = 0; i < 3; i++) wr({8'hA0, $urandom});
    tx_force = 0;
    wr({8'hB0, $urandom});
    chk("t4_pop", 64'(bus.out_valid), 64'd1);
    chk("t4_level", 64'(level), 64'd3);
    drain("t4_drain");
    busy_len = 20;
    for (int i = 0; i < 6; i++) wr({8'hC0, $urandom});
    chk("t5_level", 64'(level), 64'd5);
    rst = 1;
    cyc(1);
    rst = 0;
    chk("t5_level_rst", 64'(level), 64'd0);
    chk("t5_empty_rst", 64'(empty), 64'd1);
    chk("t5_out_valid_rst", 64'(bus.out_valid), 64'd0);
    chk("t5_overflow_rst", 64'(overflow), 64'd0);
`ifdef TDC_QUEUE_DROP_COUNT_EN
    chk("t5_drop_count_rst", 64'(drop_count), 64'd0);
`endif
    p0 = pulses;
    cyc(40);
    chk("t5_no_pulse", 64'(pulses), 64'(p0));
    busy_len = 0;
    tx_force = 1;
    for (int i = 0; i < 8; i++) wr({8'hD0, $urandom});
    tx_force = 0;
    wr({8'hEE, $urandom});
    chk("t6_pop", 64'(bus.out_valid), 64'd1);
    chk("t6_level", 64'(level), 64'd7);
    chk("t6_overflow", 64'(overflow), 64'd1);
    drain("t6_drain");
    for (int i = 0; i < 400; i++) begin
      bus.in_valid = $urandom_range(0, 99) < 35;
      bus.in_data = {$urandom, $urandom};
      tx_force = $urandom_range(0, 99) < 5;
      cyc(1);
    end
    bus.in_valid = 0;
    drain("rand_drain");
    chk("final_level", 64'(level), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
